// File: rtl/cpu_ifetch_pkg.sv
// ----------------------------------------------------------------------------
// cpu_ifetch_pkg
// Shared types, defaults and helpers for the instruction fetch unit.
//   RESET_PC_DEFAULT : first fetch address after reset
//   count_width()    : width of counters that must hold 0..DEPTH inclusive
//   fetch_entry_t    : one buffered instruction with the address it came from
//   fetch_state_t    : start-up state of the request issuer
// ----------------------------------------------------------------------------
package cpu_ifetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hFFFF_0000;
    localparam int          DEPTH_DEFAULT    = 4;

    // The issuer stays quiet until the first clock edge after reset release.
    typedef enum logic {
        FETCH_HALT,
        FETCH_RUN
    } fetch_state_t;

    // Packed so the FIFO stores it as a single 64-bit word.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    // Counters such as outstanding/discard/count must reach DEPTH itself,
    // so they need one bit more than the pointer width.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Instruction addresses are always word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/cpu_ifetch_fifo.sv
// ----------------------------------------------------------------------------
// cpu_ifetch_fifo
// Small synchronous FIFO holding fetched {instr, pc} entries.
// Ports:
//   clock      : clock
//   reset      : asynchronous, active-low
//   push       : write push_data at the tail this cycle
//   push_data  : entry to write
//   pop        : drop the head entry this cycle
//   flush      : empty the FIFO (wins over push and pop)
//   count      : number of valid entries, 0..DEPTH
//   head       : head entry, all zeros while the FIFO is empty
// ----------------------------------------------------------------------------
module cpu_ifetch_fifo
    import cpu_ifetch_pkg::*;
#(
    parameter  int DEPTH = DEPTH_DEFAULT,
    localparam int CW    = count_width(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [CW-1:0] count,
    output fetch_entry_t  head
);

    localparam int            PW      = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Pop only real entries; a push at full is allowed only when the head
    // leaves in the same cycle (the slot being written is the one popped).
    always_comb begin
        do_pop  = pop && (count != '0);
        do_push = push && ((count != FULL) || do_pop);
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clock) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // An empty FIFO presents zeros so the decode outputs are clean after
    // reset and after a flush.
    always_comb begin
        head = '0;
        if (count != '0) begin
            head = mem[rd_ptr];
        end
    end

endmodule

// File: rtl/cpu_ifetch.sv
// ----------------------------------------------------------------------------
// cpu_ifetch
// Instruction fetch unit. Issues word reads to instruction memory, buffers
// the in-order responses and hands them to the decoder with their PC.
// A redirect from the ALU stage flushes the buffer and drops every response
// that was already in flight.
// Ports:
//   clock, reset        : clock; asynchronous active-low reset
//   imem_req/imem_addr  : read request and word address to memory
//   imem_ready          : memory accepts the request this cycle
//   imem_rvalid/rdata   : in-order read response
//   p4_jump/jump_addr   : redirect request and target
//   p2_valid/p2_ready   : instruction handshake towards the decoder
//   p2_instr/p2_pc      : head instruction and its address
// ----------------------------------------------------------------------------
module cpu_ifetch
    import cpu_ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = DEPTH_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        p4_jump,
    input  logic [31:0] p4_jump_addr,
    output logic        p2_valid,
    input  logic        p2_ready,
    output logic [31:0] p2_instr,
    output logic [31:0] p2_pc
);

    localparam int            CW        = count_width(DEPTH);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW:0]   DEPTH_SUM = (CW+1)'(DEPTH);

    fetch_state_t  state;
    fetch_state_t  state_next;

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] fifo_count;

    logic [CW:0]   credit_sum;
    logic          fetch_enable;
    logic          accept;
    logic          resp_valid;
    logic          push;
    logic          drop;
    logic          pop;
    logic [CW-1:0] outstanding_after_resp;
    logic [CW-1:0] outstanding_next;
    logic [31:0]   jump_target;

    fetch_entry_t  push_entry;
    fetch_entry_t  head_entry;

    // Start-up state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= FETCH_HALT;
        end else begin
            state <= state_next;
        end
    end

    // Requests are held off for exactly one edge after reset release, then
    // the issuer runs until the next reset.
    always_comb begin
        state_next   = state;
        fetch_enable = 1'b0;
        case (state)
            FETCH_HALT: begin
                state_next = FETCH_RUN;
            end
            FETCH_RUN: begin
                fetch_enable = 1'b1;
            end
            default: begin
                state_next = FETCH_HALT;
            end
        endcase
    end

    // Credit rule: every request in flight already owns a FIFO slot, so a
    // response can always be pushed. The sum is one bit wider so it cannot
    // overflow. imem_ready is deliberately not part of imem_req.
    always_comb begin
        credit_sum  = {1'b0, outstanding} + {1'b0, fifo_count};
        imem_req    = fetch_enable && !p4_jump && (credit_sum < DEPTH_SUM);
        imem_addr   = fetch_pc;
        accept      = imem_req && imem_ready;
        jump_target = word_align(p4_jump_addr);
    end

    // Response bookkeeping. A response with nothing outstanding is a
    // protocol error and is ignored outright. Responses in a jump cycle are
    // stale by definition and never reach the FIFO.
    always_comb begin
        resp_valid             = imem_rvalid && (outstanding != '0);
        outstanding_after_resp = resp_valid ? (outstanding - CNT_ONE) : outstanding;
        outstanding_next       = accept ? (outstanding_after_resp + CNT_ONE)
                                        : outstanding_after_resp;
        push                   = resp_valid && !p4_jump && (discard == '0);
        drop                   = resp_valid && !p4_jump && (discard != '0);
        pop                    = p2_valid && p2_ready && !p4_jump;
        push_entry             = '{instr: imem_rdata, pc: resp_pc};
    end

    // Fetch and response address tracking. On a redirect, every request
    // still outstanding after this cycle's response belongs to the old path
    // and must be discarded when it returns.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= word_align(RESET_PC);
            resp_pc     <= word_align(RESET_PC);
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (p4_jump) begin
                fetch_pc <= jump_target;
                resp_pc  <= jump_target;
                discard  <= outstanding_after_resp;
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (push) begin
                    resp_pc <= resp_pc + 32'd4;
                end
                if (drop) begin
                    discard <= discard - CNT_ONE;
                end
            end
        end
    end

    cpu_ifetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (p4_jump),
        .count     (fifo_count),
        .head      (head_entry)
    );

    // Decoder side is presented straight from the FIFO head.
    always_comb begin
        p2_valid = (fifo_count != '0);
        p2_instr = head_entry.instr;
        p2_pc    = head_entry.pc;
    end

endmodule

// File: tb/tb_cpu_ifetch.sv
// ----------------------------------------------------------------------------
// tb_cpu_ifetch
// Self-checking bench for cpu_ifetch. A bench memory answers accepted
// requests in order after a programmable latency. A stream model tracks the
// address the next request and the next delivered instruction must carry.
// ----------------------------------------------------------------------------
module tb_cpu_ifetch;
    import cpu_ifetch_pkg::*;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'hFFFF_0000;

    logic        clock;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        p4_jump;
    logic [31:0] p4_jump_addr;
    logic        p2_valid;
    logic        p2_ready;
    logic [31:0] p2_instr;
    logic [31:0] p2_pc;

    cpu_ifetch #(
        .RESET_PC (RST_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .p4_jump      (p4_jump),
        .p4_jump_addr (p4_jump_addr),
        .p2_valid     (p2_valid),
        .p2_ready     (p2_ready),
        .p2_instr     (p2_instr),
        .p2_pc        (p2_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_req_t;

    mem_req_t    mq[$];
    int          checks;
    int          errors;
    int          cyc;
    int          latency;

    logic        reset_drive;
    logic        jump_now;
    logic [31:0] jump_target;
    logic        ready_now;
    logic        mem_ready_now;

    logic [31:0] exp_pc;
    logic [31:0] exp_fetch;

    logic        s_req;
    logic [31:0] s_addr;
    logic        s_valid;
    logic [31:0] s_pc;
    logic [31:0] s_instr;

    logic        track_stale;
    logic [31:0] track_addr;
    int          stale_cnt;

    int          first_req;
    int          first_valid;
    int          gap;
    int          pc_n;
    logic [31:0] pcs [3];
    int          nreq;
    int          nvalid;
    int          guard;
    logic        seen_old;
    logic [31:0] got_pc;
    logic [31:0] got_instr;

    // Contents of the bench instruction memory.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
    endfunction

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison of the DUT against the stream model.
    task automatic checkOutput();
        logic [31:0] in_pipe;
        if (s_valid) begin
            checkValue("p2_pc", s_pc, exp_pc);
            checkValue("p2_instr", s_instr, memWord(exp_pc));
        end
        if (s_req) begin
            checkValue("imem_addr", s_addr, exp_fetch);
            in_pipe = (exp_fetch - exp_pc) >> 2;
            checkValue("credit_limit", {31'b0, (in_pipe < DEPTH)}, 32'd1);
        end
        if (p4_jump) begin
            checkValue("req_in_jump", {31'b0, s_req}, 32'd0);
        end
    endtask

    // One clock cycle: drive inputs and memory response at the falling edge,
    // sample, compare, then advance the model by what the rising edge does.
    task automatic applyStimulus();
        mem_req_t r;
        @(negedge clock);
        reset        = reset_drive;
        imem_rvalid  = 1'b0;
        imem_rdata   = '0;
        p4_jump      = jump_now;
        p4_jump_addr = jump_target;
        p2_ready     = ready_now;
        imem_ready   = mem_ready_now;
        if (!reset) begin
            mq.delete();
            exp_pc    = RST_PC;
            exp_fetch = RST_PC;
        end else if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memWord(mq[0].addr);
            if (track_stale) begin
                if (mq[0].addr == track_addr) track_stale = 1'b0;
                else stale_cnt++;
            end
            void'(mq.pop_front());
        end
        #1;
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_valid = p2_valid;
        s_pc    = p2_pc;
        s_instr = p2_instr;
        if (reset) begin
            checkOutput();
            if (p4_jump) begin
                exp_pc    = jump_target & 32'hFFFF_FFFC;
                exp_fetch = jump_target & 32'hFFFF_FFFC;
            end else begin
                if (s_valid && p2_ready) exp_pc = exp_pc + 32'd4;
                if (s_req && imem_ready) begin
                    r.addr = s_addr;
                    r.due  = cyc + latency;
                    mq.push_back(r);
                    exp_fetch = exp_fetch + 32'd4;
                end
            end
        end
        cyc++;
    endtask

    task automatic waitValid(input int limit);
        for (int i = 0; i < limit; i++) begin
            applyStimulus();
            if (s_valid) return;
        end
        checkValue("valid_timeout", {31'b0, s_valid}, 32'd1);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkValue({tag, "_req"},   {31'b0, imem_req}, 32'd0);
        checkValue({tag, "_addr"},  imem_addr, RST_PC);
        checkValue({tag, "_valid"}, {31'b0, p2_valid}, 32'd0);
        checkValue({tag, "_instr"}, p2_instr, 32'd0);
        checkValue({tag, "_pc"},    p2_pc, 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        checks = 0; errors = 0; cyc = 0; latency = 1;
        reset = 1'b0; reset_drive = 1'b0;
        jump_now = 1'b0; jump_target = '0; ready_now = 1'b1; mem_ready_now = 1'b1;
        imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
        p4_jump = 1'b0; p4_jump_addr = '0; p2_ready = 1'b1;
        exp_pc = RST_PC; exp_fetch = RST_PC;
        track_stale = 1'b0; track_addr = '0; stale_cnt = 0;

        repeat (3) @(negedge clock);
        #1;
        checkResetOutputs("reset");

        // Cold start, 1-cycle memory, decoder always ready.
        $display("[TB] streaming from reset");
        reset_drive = 1'b1;
        first_req = -1; first_valid = -1; gap = 0; pc_n = 0;
        for (int i = 0; i < 3; i++) pcs[i] = '0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus();
            if (s_req && first_req < 0) first_req = cyc - 1;
            if (s_valid) begin
                if (first_valid < 0) first_valid = cyc - 1;
                if (pc_n < 3) begin
                    pcs[pc_n] = s_pc;
                    pc_n++;
                end
            end else if (first_valid >= 0) begin
                gap++;
            end
        end
        checkValue("first_latency", 32'(first_valid - first_req), 32'd2);
        checkValue("stream_pc0", pcs[0], 32'hFFFF_0000);
        checkValue("stream_pc1", pcs[1], 32'hFFFF_0004);
        checkValue("stream_pc2", pcs[2], 32'hFFFF_0008);
        checkValue("stream_gaps", 32'(gap), 32'd0);
        for (int i = 0; i < 10; i++) begin
            mem_ready_now = (i % 2 == 0);
            applyStimulus();
        end
        mem_ready_now = 1'b1;

        // Jump with the decoder stalled: the FIFO fills, then drains.
        $display("[TB] stall with full FIFO");
        ready_now = 1'b0;
        jump_now = 1'b1; jump_target = 32'h0000_0400;
        applyStimulus();
        jump_now = 1'b0;
        nreq = 0; nvalid = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus();
            if (s_req && imem_ready) nreq++;
            if (i >= 10 && s_valid) nvalid++;
        end
        checkValue("stall_requests", 32'(nreq), 32'd4);
        checkValue("stall_valid_held", 32'(nvalid), 32'd10);
        checkValue("stall_req_low", {31'b0, s_req}, 32'd0);
        ready_now = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus();
            checkValue("drain_valid", {31'b0, s_valid}, 32'd1);
            checkValue("drain_pc", s_pc, 32'h400 + 32'(4 * i));
        end
        nreq = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus();
            if (s_req) nreq++;
        end
        checkValue("resume_fetch", {31'b0, (nreq > 0)}, 32'd1);

        // Latency 3, jump with three requests in flight.
        $display("[TB] jump over in-flight responses");
        latency = 3;
        guard = 0;
        while (mq.size() != 3 && guard < 60) begin
            applyStimulus();
            guard++;
        end
        checkValue("reach_3_outstanding", 32'(mq.size()), 32'd3);
        track_stale = 1'b1; track_addr = 32'h0000_1000; stale_cnt = 0;
        jump_now = 1'b1; jump_target = 32'h0000_1000;
        applyStimulus();
        jump_now = 1'b0;
        waitValid(30);
        got_pc = s_pc; got_instr = s_instr;
        checkValue("dropped_count", 32'(stale_cnt), 32'd3);
        checkValue("jump_first_pc", got_pc, 32'h0000_1000);
        checkValue("jump_first_instr", got_instr, memWord(32'h0000_1000));
        track_stale = 1'b0;

        // Jump in the same cycle as a response, with the decoder ready.
        $display("[TB] jump coinciding with a response");
        latency = 2;
        guard = 0;
        while (!(mq.size() > 0 && mq[0].due == cyc && s_valid) && guard < 60) begin
            applyStimulus();
            guard++;
        end
        checkValue("resp_slot_found", {31'b0, (guard < 60)}, 32'd1);
        jump_now = 1'b1; jump_target = 32'h0000_2003;
        applyStimulus();
        jump_now = 1'b0;
        checkValue("jump_cycle_req", {31'b0, s_req}, 32'd0);
        applyStimulus();
        checkValue("post_jump_req", {31'b0, s_req}, 32'd1);
        checkValue("post_jump_addr", s_addr, 32'h0000_2000);
        waitValid(30);
        checkValue("unaligned_jump_pc", s_pc, 32'h0000_2000);
        checkValue("unaligned_jump_instr", s_instr, memWord(32'h0000_2000));

        // Back-to-back jumps with slow memory: only the latest target counts.
        $display("[TB] back-to-back jumps");
        latency = 4;
        repeat (8) applyStimulus();
        jump_now = 1'b1; jump_target = 32'h0000_0100;
        applyStimulus();
        jump_target = 32'h0000_0200;
        applyStimulus();
        jump_now = 1'b0;
        seen_old = 1'b0;
        got_pc = '0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus();
            if (s_valid && s_pc[31:8] == 24'h000001) seen_old = 1'b1;
            if (s_valid && got_pc == 32'd0) got_pc = s_pc;
        end
        checkValue("b2b_first_pc", got_pc, 32'h0000_0200);
        checkValue("b2b_no_0x100", {31'b0, seen_old}, 32'd0);

        // Reset in the middle of a burst.
        $display("[TB] reset mid-burst");
        latency = 3;
        guard = 0;
        while (mq.size() != 2 && guard < 60) begin
            applyStimulus();
            guard++;
        end
        checkValue("reach_2_outstanding", 32'(mq.size()), 32'd2);
        @(negedge clock);
        reset = 1'b0; reset_drive = 1'b0;
        imem_rvalid = 1'b0;
        #1;
        checkResetOutputs("midreset");
        mq.delete();
        exp_pc = RST_PC; exp_fetch = RST_PC;
        repeat (2) applyStimulus();
        reset_drive = 1'b1;
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus();
            if (s_req) break;
        end
        checkValue("restart_req", {31'b0, s_req}, 32'd1);
        checkValue("restart_addr", s_addr, RST_PC);
        waitValid(30);
        checkValue("restart_pc", s_pc, RST_PC);
        checkValue("restart_instr", s_instr, memWord(RST_PC));
        repeat (10) applyStimulus();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
